// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment bank.
// Shadows a multi-digit hex value and swaps in new values only at frame wrap.
module disp_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 100000,
  parameter int GAP    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  value_valid,
  output logic                  value_ready,
  output logic [DIGITS-1:0]     an,
  output logic [3:0]            nibble,
  output logic                  frame_done
);

  localparam int CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = $clog2(DIGITS);

  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic {
    GAP_S,
    SHOW_S
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   pending_val_q, pending_val_d;
  logic [DIGITS-1:0]     pending_en_q, pending_en_d;
  logic                  pending_flag_q, pending_flag_d;
  logic [4*DIGITS-1:0]   active_val_q, active_val_d;
  logic [DIGITS-1:0]     active_en_q, active_en_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [3:0]            nibble_q, nibble_d;
  logic                  frame_done_q, frame_done_d;
  logic                  ready_q, ready_d;

  logic                  transfer;
  logic                  show_last;
  logic                  wrap;
  logic [DIGITS-1:0]     lit_an;

  // Anode pattern for the current digit: only bit idx may drop, and only if enabled.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lit
      assign lit_an[gi] = !((idx_q == IW'(gi)) && active_en_q[gi]);
    end
  endgenerate

  assign transfer  = value_valid && ready_q;
  assign show_last = (state_q == SHOW_S) && (cnt_q == DWELL_LAST);
  assign wrap      = show_last && (idx_q == IDX_LAST);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    pending_val_d  = pending_val_q;
    pending_en_d   = pending_en_q;
    pending_flag_d = pending_flag_q;
    active_val_d   = active_val_q;
    active_en_d    = active_en_q;
    an_d           = an_q;
    nibble_d       = nibble_q;
    frame_done_d   = 1'b0;
    ready_d        = ready_q;

    case (state_q)
      GAP_S: begin
        if (cnt_q == GAP_LAST) begin
          state_d = SHOW_S;
          cnt_d   = '0;
          an_d    = lit_an;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHOW_S: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = GAP_S;
          cnt_d   = '0;
          an_d    = '1;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = GAP_S;
        cnt_d   = '0;
        an_d    = '1;
      end
    endcase

    if (wrap) begin
      frame_done_d = 1'b1;
      if (pending_flag_q) begin
        active_val_d   = pending_val_q;
        active_en_d    = pending_en_q;
        pending_flag_d = 1'b0;
        ready_d        = 1'b1;
      end
    end

    // A transfer can only happen with nothing pending, so it never collides with the load above.
    if (transfer) begin
      pending_val_d  = value;
      pending_en_d   = digit_en;
      pending_flag_d = 1'b1;
      ready_d        = 1'b0;
    end

    // Present the next digit's code during the gap so the decoder settles before lighting.
    if (show_last) begin
      nibble_d = active_val_d[{idx_d, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= GAP_S;
      idx_q          <= '0;
      cnt_q          <= '0;
      pending_val_q  <= '0;
      pending_en_q   <= '0;
      pending_flag_q <= 1'b0;
      active_val_q   <= '0;
      active_en_q    <= '0;
      an_q           <= '1;
      nibble_q       <= '0;
      frame_done_q   <= 1'b0;
      ready_q        <= 1'b1;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      pending_val_q  <= pending_val_d;
      pending_en_q   <= pending_en_d;
      pending_flag_q <= pending_flag_d;
      active_val_q   <= active_val_d;
      active_en_q    <= active_en_d;
      an_q           <= an_d;
      nibble_q       <= nibble_d;
      frame_done_q   <= frame_done_d;
      ready_q        <= ready_d;
    end
  end

  assign value_ready = ready_q;
  assign an          = an_q;
  assign nibble      = nibble_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: frame-position model checked every cycle, plus
// directed loads, wrap-edge transfer, async reset and a randomized phase.
module tb_disp_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DWELL  = 5;
  localparam int GAP    = 2;
  localparam int SLOT   = DWELL + GAP;
  localparam int FRAME  = DIGITS * SLOT;

  logic                clk = 1'b0;
  logic                reset;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   digit_en;
  logic                value_valid;
  logic                value_ready;
  logic [DIGITS-1:0]   an;
  logic [3:0]          nibble;
  logic                frame_done;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  disp_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .GAP(GAP)) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .digit_en    (digit_en),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .an          (an),
    .nibble      (nibble),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: t = cycles since reset release; position in frame decides everything.
  int                  t = 0;
  logic [4*DIGITS-1:0] m_act_val = '0;
  logic [DIGITS-1:0]   m_act_en = '0;
  logic [4*DIGITS-1:0] m_pend_val = '0;
  logic [DIGITS-1:0]   m_pend_en = '0;
  bit                  m_pflag = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t          <= 0;
      m_act_val  <= '0;
      m_act_en   <= '0;
      m_pflag    <= 1'b0;
    end else begin
      if ((t % FRAME) == FRAME - 1 && m_pflag) begin
        m_act_val <= m_pend_val;
        m_act_en  <= m_pend_en;
        m_pflag   <= 1'b0;
      end
      if (value_valid && !m_pflag) begin
        m_pend_val <= value;
        m_pend_en  <= digit_en;
        m_pflag    <= 1'b1;
      end
      t <= t + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int p, d, ph;
      logic [DIGITS-1:0] e_an;
      p  = t % FRAME;
      d  = p / SLOT;
      ph = p % SLOT;
      e_an = '1;
      if (ph >= GAP && m_act_en[d]) e_an[d] = 1'b0;
      check("an", 32'(an), 32'(e_an));
      check("nibble", 32'(nibble), 32'(m_act_val[d*4 +: 4]));
      check("frame_done", 32'(frame_done), 32'((p == 0) && (t > 0)));
      check("value_ready", 32'(value_ready), 32'(!m_pflag));
    end
  end

  task automatic wait_t(input int target);
    for (int i = 0; i < 2000; i++) begin
      if (t == target) return;
      @(negedge clk);
    end
    check("wait_timeout", 32'(t), 32'(target));
  endtask

  initial begin
    reset       = 1'b1;
    value_valid = 1'b0;
    value       = '0;
    digit_en    = '0;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    check("rst_an", 32'(an), 'hF);
    check("rst_ready", 32'(value_ready), 1);
    check("rst_fd", 32'(frame_done), 0);

    // First load right after reset, second held while the first is pending.
    value_valid = 1'b1; value = 16'h1A2F; digit_en = 4'hF;
    wait_t(1);  value_valid = 1'b0;
    check("ready_drop", 32'(value_ready), 0);
    wait_t(3);  value_valid = 1'b1; value = 16'h5C3B; digit_en = 4'b0101;
    wait_t(10); check("dark_frame0", 32'(an), 'hF);
    wait_t(28); check("wrap_fd", 32'(frame_done), 1); check("wrap_ready", 32'(value_ready), 1);
    wait_t(29); value_valid = 1'b0; check("second_taken", 32'(value_ready), 0);
    wait_t(30); check("f1_an0", 32'(an), 'hE); check("f1_nib0", 32'(nibble), 'hF);
    wait_t(37); check("f1_an1", 32'(an), 'hD); check("f1_nib1", 32'(nibble), 'h2);
    wait_t(44); check("f1_an2", 32'(an), 'hB); check("f1_nib2", 32'(nibble), 'hA);
    wait_t(51); check("f1_an3", 32'(an), 'h7); check("f1_nib3", 32'(nibble), 'h1);
    wait_t(56); check("f2_fd", 32'(frame_done), 1); check("f2_ready", 32'(value_ready), 1);
    wait_t(58); check("blk_an0", 32'(an), 'hE); check("blk_nib0", 32'(nibble), 'hB);
    wait_t(65); check("blk_an1", 32'(an), 'hF); check("blk_nib1", 32'(nibble), 'h3);
    wait_t(72); check("blk_an2", 32'(an), 'hB); check("blk_nib2", 32'(nibble), 'hC);
    wait_t(79); check("blk_an3", 32'(an), 'hF); check("blk_nib3", 32'(nibble), 'h5);

    // Transfer exactly on the wrap edge: applied one frame later.
    wait_t(83); value_valid = 1'b1; value = 16'h9D70; digit_en = 4'hF;
    wait_t(84); value_valid = 1'b0;
    check("we_fd", 32'(frame_done), 1); check("we_ready", 32'(value_ready), 0);
    wait_t(86);  check("we_old_an", 32'(an), 'hE); check("we_old_nib", 32'(nibble), 'hB);
    wait_t(112); check("we_apply_fd", 32'(frame_done), 1); check("we_apply_rdy", 32'(value_ready), 1);
    wait_t(114); check("we_new_an", 32'(an), 'hE); check("we_new_nib", 32'(nibble), 'h0);

    // Async reset mid-SHOW with a load pending.
    value_valid = 1'b1; value = 16'h4444; digit_en = 4'hF;
    wait_t(115); value_valid = 1'b0;
    check("pend_ready", 32'(value_ready), 0);
    wait_t(117);
    check("pre_rst_lit", 32'(an), 'hE);
    #2 reset = 1'b1;
    #1;
    check("arst_an", 32'(an), 'hF);
    check("arst_fd", 32'(frame_done), 0);
    check("arst_ready", 32'(value_ready), 1);
    check("arst_nib", 32'(nibble), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_t(30); check("dark_after_rst0", 32'(an), 'hE ^ 'h1);
    wait_t(33); check("dark_after_rst1", 32'(an), 'hF);

    // Randomized traffic; the per-cycle model does the checking.
    for (int i = 0; i < 600; i++) begin
      value_valid = ($urandom_range(0, 2) == 0);
      value       = 16'($urandom);
      digit_en    = 4'($urandom);
      @(negedge clk);
    end
    value_valid = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
